flash_rd_arb: RTL and testbench

Read-side initiator for the on-board parallel flash (23-bit byte address, 8-bit asynchronous data). It serves two clients, the CPU PRG fetch path and the PPU CHR fetch path, over a req/ack handshake. Each client address is an offset into its own 1 MiB window: PRG at 0x000000, CHR at 0x400000. The block drives the flash address, waits a programmable access time, captures the byte and returns it to the client that was granted. Round-robin arbitration between the two clients prevents either one from starving the other.

---
 rtl/flash_rd_arb_pkg.sv | 13 +
 rtl/flash_rd_arb_if.sv | 35 +++
 rtl/flash_rd_arb.sv | 91 +++++++++
 tb/tb_flash_rd_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_rd_arb_pkg.sv
// Shared widths, default window bases and state/client encodings
// for the parallel-flash read arbiter.
package flash_pkg;
   localparam int FLASH_AW  = 23;
   localparam int CLIENT_AW = 20;
   localparam int DW        = 8;

   localparam logic [FLASH_AW-1:0] PRG_BASE_DEF = 23'h000000;
   localparam logic [FLASH_AW-1:0] CHR_BASE_DEF = 23'h400000;

   typedef enum logic {IDLE, WAIT} state_e;
   typedef enum logic {CL_PRG, CL_CHR} client_e;
endpackage

// File: rtl/flash_rd_arb_if.sv
// Client req/ack buses plus the flash address/data pins of the
// read arbiter, bundled for a single port connection.
interface flash_rd_arb_if
   import flash_pkg::*;
();
   logic                 i_prg_req;
   logic [CLIENT_AW-1:0] i_prg_addr;
   logic                 o_prg_ack;
   logic [DW-1:0]        o_prg_data;
   logic                 i_chr_req;
   logic [CLIENT_AW-1:0] i_chr_addr;
   logic                 o_chr_ack;
   logic [DW-1:0]        o_chr_data;
   logic [FLASH_AW-1:0]  o_flash_addr;
   logic [DW-1:0]        i_flash_q;
   logic                 o_busy;

   modport slave (
      input  i_prg_req, i_prg_addr,
      input  i_chr_req, i_chr_addr,
      input  i_flash_q,
      output o_prg_ack, o_prg_data,
      output o_chr_ack, o_chr_data,
      output o_flash_addr, o_busy
   );

   modport master (
      output i_prg_req, i_prg_addr,
      output i_chr_req, i_chr_addr,
      output i_flash_q,
      input  o_prg_ack, o_prg_data,
      input  o_chr_ack, o_chr_data,
      input  o_flash_addr, o_busy
   );
endinterface

// File: rtl/flash_rd_arb.sv
// Round-robin PRG/CHR read initiator for the asynchronous parallel
// flash: drive address, hold WAIT_CYC clocks, sample, ack the owner.
module flash_rd_arb
   import flash_pkg::*;
#(
   parameter int                  WAIT_CYC = 4,
   parameter logic [FLASH_AW-1:0] PRG_BASE = PRG_BASE_DEF,
   parameter logic [FLASH_AW-1:0] CHR_BASE = CHR_BASE_DEF
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   flash_rd_arb_if.slave  bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;
   localparam logic [3:0] CNT_LD = 4'(WAIT_CYC - 1);

   logic [0:0]          state;
   logic [3:0]          cnt;
   client_e             grant;
   client_e             last_grant;
   logic [FLASH_AW-1:0] faddr;
   logic                prg_ack;
   logic                chr_ack;
   logic [DW-1:0]       prg_data;
   logic [DW-1:0]       chr_data;

   logic prg_elig;
   logic chr_elig;
   logic pick_chr;

   // a client whose ack is high this cycle must not be re-granted
   assign prg_elig = bus.i_prg_req & ~prg_ack;
   assign chr_elig = bus.i_chr_req & ~chr_ack;
   assign pick_chr = chr_elig &
                     (~prg_elig | (last_grant == CL_PRG));

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         grant      <= CL_PRG;
         last_grant <= CL_CHR;
         faddr      <= '0;
         prg_ack    <= 1'b0;
         chr_ack    <= 1'b0;
         prg_data   <= '0;
         chr_data   <= '0;
      end else begin
         prg_ack <= 1'b0;
         chr_ack <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (prg_elig | chr_elig) begin
                  faddr <= pick_chr
                           ? (CHR_BASE | {3'b0, bus.i_chr_addr})
                           : (PRG_BASE | {3'b0, bus.i_prg_addr});
                  grant      <= pick_chr ? CL_CHR : CL_PRG;
                  last_grant <= pick_chr ? CL_CHR : CL_PRG;
                  cnt        <= CNT_LD;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (grant == CL_PRG) begin
                     prg_data <= bus.i_flash_q;
                     prg_ack  <= 1'b1;
                  end else begin
                     chr_data <= bus.i_flash_q;
                     chr_ack  <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_prg_ack    = prg_ack;
   assign bus.o_prg_data   = prg_data;
   assign bus.o_chr_ack    = chr_ack;
   assign bus.o_chr_data   = chr_data;
   assign bus.o_flash_addr = faddr;
   assign bus.o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_flash_rd_arb.sv
// Directed bench for flash_rd_arb: reset, alternation, window edges,
// mid-access reset and a WAIT_CYC=1 instance.
module tb_flash_rd_arb;
   import flash_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   flash_rd_arb_if bus ();
   flash_rd_arb_if bus1 ();

   flash_rd_arb #(.WAIT_CYC(4)) dut (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (bus)
   );

   flash_rd_arb #(.WAIT_CYC(1)) dut1 (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (bus1)
   );

   function automatic logic [7:0] fbyte(input logic [22:0] a);
      if (a == 23'h000010) return 8'hA5;
      if (a == 23'h40ABCD) return 8'h3C;
      return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
   endfunction

   assign bus.i_flash_q  = fbyte(bus.o_flash_addr);
   assign bus1.i_flash_q = fbyte(bus1.o_flash_addr);

   typedef struct {
      logic        preq;
      logic [19:0] paddr;
      logic        creq;
      logic [19:0] caddr;
      logic        pack;
      logic        cack;
      logic [22:0] faddr;
      logic [7:0]  pd;
      logic [7:0]  cd;
      logic        busy;
   } vec_t;

   vec_t tbl[12];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t mk(
      input logic pr, input logic [19:0] pa,
      input logic cr, input logic [19:0] ca,
      input logic pk, input logic ck,
      input logic [22:0] fa, input logic [7:0] pd,
      input logic [7:0] cd, input logic by);
      vec_t v;
      v.preq = pr; v.paddr = pa; v.creq = cr; v.caddr = ca;
      v.pack = pk; v.cack = ck; v.faddr = fa;
      v.pd = pd; v.cd = cd; v.busy = by;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic pr, input logic [19:0] pa,
                         input logic cr, input logic [19:0] ca);
      bus.i_prg_req  = pr;
      bus.i_prg_addr = pa;
      bus.i_chr_req  = cr;
      bus.i_chr_addr = ca;
   endtask

   initial begin
      int ack_cyc[4];
      logic ack_chr[4];
      int n_ack;
      int stray;

      bus1.i_prg_req  = 1'b0;
      bus1.i_prg_addr = '0;
      bus1.i_chr_req  = 1'b0;
      bus1.i_chr_addr = '0;
      set_in(1'b1, 20'h00010, 1'b1, 20'h0ABCD);

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst prg_ack", 32'(bus.o_prg_ack), 0);
         chk("rst chr_ack", 32'(bus.o_chr_ack), 0);
         chk("rst busy", 32'(bus.o_busy), 0);
         chk("rst faddr", 32'(bus.o_flash_addr), 0);
         chk("rst prg_data", 32'(bus.o_prg_data), 0);
         chk("rst chr_data", 32'(bus.o_chr_data), 0);
      end

      rstn = 1'b1;
      tick();
      chk("first grant faddr", 32'(bus.o_flash_addr), 32'h000010);
      chk("first grant busy", 32'(bus.o_busy), 1);

      foreach (ack_cyc[i]) begin
         ack_cyc[i] = 0;
         ack_chr[i] = 1'b0;
      end
      n_ack = 0;
      for (int c = 2; c <= 40 && n_ack < 4; c++) begin
         tick();
         if (bus.o_prg_ack === 1'b1 || bus.o_chr_ack === 1'b1) begin
            ack_cyc[n_ack] = c;
            ack_chr[n_ack] = bus.o_chr_ack;
            if (bus.o_prg_ack === 1'b1)
               chk("alt prg_data", 32'(bus.o_prg_data), 32'hA5);
            else
               chk("alt chr_data", 32'(bus.o_chr_data), 32'h3C);
            n_ack++;
         end
      end
      set_in(1'b0, 20'h0, 1'b0, 20'h0);
      chk("alt ack count", 32'(n_ack), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("alt ack%0d cycle", i), 32'(ack_cyc[i]),
             32'(5 * (i + 1)));
         chk($sformatf("alt ack%0d client", i), 32'(ack_chr[i]),
             32'(i % 2));
      end

      tbl[0]  = mk(1'b1, 20'hFFFFF, 1'b0, 20'h0, 1'b0, 1'b0,
                   23'h0FFFFF, 8'hA5, 8'h3C, 1'b1);
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = tbl[0];
      tbl[4]  = mk(1'b1, 20'hFFFFF, 1'b0, 20'h0, 1'b1, 1'b0,
                   23'h0FFFFF, 8'h55, 8'h3C, 1'b0);
      tbl[5]  = mk(1'b1, 20'hFFFFF, 1'b0, 20'h0, 1'b0, 1'b0,
                   23'h0FFFFF, 8'h55, 8'h3C, 1'b0);
      tbl[6]  = mk(1'b0, 20'h0, 1'b1, 20'hFFFFF, 1'b0, 1'b0,
                   23'h4FFFFF, 8'h55, 8'h3C, 1'b1);
      tbl[7]  = mk(1'b0, 20'h0, 1'b0, 20'h00000, 1'b0, 1'b0,
                   23'h4FFFFF, 8'h55, 8'h3C, 1'b1);
      tbl[8]  = tbl[7];
      tbl[9]  = tbl[7];
      tbl[10] = mk(1'b0, 20'h0, 1'b0, 20'h00000, 1'b0, 1'b1,
                   23'h4FFFFF, 8'h55, 8'h15, 1'b0);
      tbl[11] = mk(1'b0, 20'h0, 1'b0, 20'h00000, 1'b0, 1'b0,
                   23'h4FFFFF, 8'h55, 8'h15, 1'b0);

      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].preq, tbl[i].paddr, tbl[i].creq, tbl[i].caddr);
         tick();
         chk($sformatf("r%0d prg_ack", i), 32'(bus.o_prg_ack),
             32'(tbl[i].pack));
         chk($sformatf("r%0d chr_ack", i), 32'(bus.o_chr_ack),
             32'(tbl[i].cack));
         chk($sformatf("r%0d faddr", i), 32'(bus.o_flash_addr),
             32'(tbl[i].faddr));
         chk($sformatf("r%0d prg_data", i), 32'(bus.o_prg_data),
             32'(tbl[i].pd));
         chk($sformatf("r%0d chr_data", i), 32'(bus.o_chr_data),
             32'(tbl[i].cd));
         chk($sformatf("r%0d busy", i), 32'(bus.o_busy),
             32'(tbl[i].busy));
      end

      set_in(1'b1, 20'h00010, 1'b0, 20'h0);
      tick();
      tick();
      tick();
      chk("midrst busy before", 32'(bus.o_busy), 1);
      rstn = 1'b0;
      tick();
      chk("midrst busy", 32'(bus.o_busy), 0);
      chk("midrst prg_ack", 32'(bus.o_prg_ack), 0);
      chk("midrst faddr", 32'(bus.o_flash_addr), 0);
      chk("midrst prg_data", 32'(bus.o_prg_data), 0);
      chk("midrst chr_data", 32'(bus.o_chr_data), 0);
      rstn = 1'b1;
      set_in(1'b0, 20'h0, 1'b0, 20'h0);
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.o_prg_ack !== 1'b0) stray++;
      end
      chk("midrst no late ack", 32'(stray), 0);

      bus1.i_prg_req  = 1'b1;
      bus1.i_prg_addr = 20'h00010;
      tick();
      chk("w1 c1 busy", 32'(bus1.o_busy), 1);
      chk("w1 c1 ack", 32'(bus1.o_prg_ack), 0);
      chk("w1 c1 faddr", 32'(bus1.o_flash_addr), 32'h000010);
      tick();
      chk("w1 c2 ack", 32'(bus1.o_prg_ack), 1);
      chk("w1 c2 data", 32'(bus1.o_prg_data), 32'hA5);
      bus1.i_prg_req = 1'b0;
      tick();
      chk("w1 c3 ack", 32'(bus1.o_prg_ack), 0);
      chk("w1 c3 busy", 32'(bus1.o_busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
